seg_scan_decoder: RTL and testbench

Receive-side monitor for the multiplexed 4-digit 7-segment scan bus (`anodes`/`cathodes`) driven by the level-meter display path. It samples the scanned lines, filters scan transitions, decodes each segment pattern back to BCD, and publishes one complete frame (hundreds, tens, units, alarm) with a validity pulse. It is used for on-chip readback/self-check and as a bench checker for the display path.

---
 rtl/seg_scan_decoder.sv | 229 ++++++++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg_scan_decoder
//
// Receive-side monitor for a multiplexed 4-digit 7-segment scan bus. The
// scanned anode/cathode lines are synchronized, filtered for stability,
// decoded back to BCD and assembled into frames (hundreds, tens, units,
// alarm). A complete, in-order frame is published with a one-cycle
// frame_valid pulse.
//
// Ports:
//   clk_100MHz   : system clock, all logic on the rising edge
//   reset        : synchronous active-low reset
//   anodes       : active-low digit enables (asynchronous to clk_100MHz)
//   cathodes     : active-low segments, [7:1] = a..g, [0] = dp
//   digit_h/t/u  : published BCD (4'hF blank, 4'hE invalid)
//   blank_h/t    : slot was blank in the last published frame
//   alarm_seg    : raw cathode pattern captured for slot 3
//   frame_valid  : one-cycle pulse when outputs are updated
//   decode_error : last published frame had an invalid digit pattern
//   seq_error    : one-cycle pulse on an out-of-order slot capture
//   scan_lost    : no frame published for FRAME_TIMEOUT cycles (sticky)
// -----------------------------------------------------------------------------
module seg_scan_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int FRAME_TIMEOUT = 1_000_000
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic [7:0] anodes,
    input  logic [7:0] cathodes,
    output logic [3:0] digit_h,
    output logic [3:0] digit_t,
    output logic [3:0] digit_u,
    output logic       blank_h,
    output logic       blank_t,
    output logic [7:0] alarm_seg,
    output logic       frame_valid,
    output logic       decode_error,
    output logic       seq_error,
    output logic       scan_lost
);

    localparam int SW = $clog2(STABLE_CYCLES);
    localparam int TW = $clog2(FRAME_TIMEOUT);
    localparam logic [SW-1:0] STABLE_MAX  = SW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_MAX = TW'(FRAME_TIMEOUT - 1);

    localparam logic [1:0] WAIT_S0 = 2'd0;
    localparam logic [1:0] GOT_S0  = 2'd1;
    localparam logic [1:0] GOT_S1  = 2'd2;
    localparam logic [1:0] GOT_S2  = 2'd3;

    // Segment pattern (a..g, active low) to BCD; dp is forced to 1 so the
    // table can be written with the familiar full-byte values.
    function automatic logic [3:0] decode_seg(input logic [6:0] seg);
        logic [3:0] code;
        case ({seg, 1'b1})
            8'h03:   code = 4'h0;
            8'h9F:   code = 4'h1;
            8'h25:   code = 4'h2;
            8'h0D:   code = 4'h3;
            8'h99:   code = 4'h4;
            8'h49:   code = 4'h5;
            8'h41:   code = 4'h6;
            8'h1F:   code = 4'h7;
            8'h01:   code = 4'h8;
            8'h09:   code = 4'h9;
            8'hFF:   code = 4'hF;
            default: code = 4'hE;
        endcase
        return code;
    endfunction

    // Anode value to {is_slot, slot_index}.
    function automatic logic [2:0] decode_slot(input logic [7:0] an);
        logic [2:0] res;
        case (an)
            8'h7F:   res = 3'b100;
            8'hBF:   res = 3'b101;
            8'hDF:   res = 3'b110;
            8'hEF:   res = 3'b111;
            default: res = 3'b000;
        endcase
        return res;
    endfunction

    logic [15:0]   sync1_r, sync2_r, prev_r;
    logic [SW-1:0] stab_cnt_r;
    logic          cap_r;
    logic [1:0]    cap_slot_r;
    logic [7:0]    cap_seg_r;
    logic [1:0]    state_r;
    logic [3:0]    h_sh_r, t_sh_r, u_sh_r;
    logic [TW-1:0] to_cnt_r;
    logic [2:0]    slot_s;
    logic          publish_s;
    logic [3:0]    cap_code_s;

    // Combinational helpers: slot of the synchronized anodes, decoded
    // captured digit, and the publish condition.
    always_comb begin
        slot_s     = decode_slot(sync2_r[15:8]);
        cap_code_s = decode_seg(cap_seg_r[7:1]);
        publish_s  = 1'b0;
        if (cap_r && (state_r == GOT_S2) && (cap_slot_r == 2'd3)) begin
            publish_s = 1'b1;
        end else begin
            publish_s = 1'b0;
        end
    end

    // Two-flop synchronizer on the full bus; idle (all lines high) after reset.
    always_ff @(posedge clk_100MHz) begin
        if (!reset) begin
            sync1_r <= 16'hFFFF;
            sync2_r <= 16'hFFFF;
        end else begin
            sync1_r <= {anodes, cathodes};
            sync2_r <= sync1_r;
        end
    end

    // Stability filter: counter saturates at STABLE_CYCLES-1, and the strobe
    // fires only on the step that reaches it, so one dwell gives one capture.
    always_ff @(posedge clk_100MHz) begin
        if (!reset) begin
            prev_r     <= 16'hFFFF;
            stab_cnt_r <= '0;
            cap_r      <= 1'b0;
            cap_slot_r <= 2'd0;
            cap_seg_r  <= 8'hFF;
        end else begin
            prev_r <= sync2_r;
            if (sync2_r != prev_r) begin
                stab_cnt_r <= '0;
                cap_r      <= 1'b0;
            end else if (stab_cnt_r != STABLE_MAX) begin
                stab_cnt_r <= stab_cnt_r + SW'(1);
                cap_r      <= ((stab_cnt_r + SW'(1)) == STABLE_MAX) && slot_s[2];
            end else begin
                cap_r <= 1'b0;
            end
            cap_slot_r <= slot_s[1:0];
            cap_seg_r  <= sync2_r[7:0];
        end
    end

    // Frame assembly FSM, shadow registers and published outputs.
    always_ff @(posedge clk_100MHz) begin
        if (!reset) begin
            state_r      <= WAIT_S0;
            h_sh_r       <= 4'h0;
            t_sh_r       <= 4'h0;
            u_sh_r       <= 4'h0;
            digit_h      <= 4'h0;
            digit_t      <= 4'h0;
            digit_u      <= 4'h0;
            blank_h      <= 1'b0;
            blank_t      <= 1'b0;
            alarm_seg    <= 8'hFF;
            frame_valid  <= 1'b0;
            decode_error <= 1'b0;
            seq_error    <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            seq_error   <= 1'b0;
            if (cap_r) begin
                case (state_r)
                    WAIT_S0: begin
                        if (cap_slot_r == 2'd0) begin
                            h_sh_r  <= cap_code_s;
                            state_r <= GOT_S0;
                        end else begin
                            state_r <= WAIT_S0;
                        end
                    end
                    GOT_S0, GOT_S1, GOT_S2: begin
                        if (cap_slot_r == state_r) begin
                            // Expected slot k+1 equals the 2-bit state encoding.
                            case (state_r)
                                GOT_S0:  t_sh_r <= cap_code_s;
                                GOT_S1:  u_sh_r <= cap_code_s;
                                default: begin
                                    alarm_seg    <= cap_seg_r;
                                    digit_h      <= h_sh_r;
                                    digit_t      <= t_sh_r;
                                    digit_u      <= u_sh_r;
                                    blank_h      <= (h_sh_r == 4'hF);
                                    blank_t      <= (t_sh_r == 4'hF);
                                    decode_error <= (h_sh_r == 4'hE) || (t_sh_r == 4'hE)
                                                    || (u_sh_r == 4'hE);
                                    frame_valid  <= 1'b1;
                                end
                            endcase
                            state_r <= (state_r == GOT_S2) ? WAIT_S0 : state_r + 2'd1;
                        end else if (cap_slot_r == 2'd0) begin
                            seq_error <= 1'b1;
                            h_sh_r    <= cap_code_s;
                            state_r   <= GOT_S0;
                        end else begin
                            seq_error <= 1'b1;
                            state_r   <= WAIT_S0;
                        end
                    end
                    default: state_r <= WAIT_S0;
                endcase
            end else begin
                state_r <= state_r;
            end
        end
    end

    // Frame timeout: publish clears both counter and flag, and takes
    // priority over an expiry landing in the same cycle.
    always_ff @(posedge clk_100MHz) begin
        if (!reset) begin
            to_cnt_r  <= '0;
            scan_lost <= 1'b0;
        end else if (publish_s) begin
            to_cnt_r  <= '0;
            scan_lost <= 1'b0;
        end else if (to_cnt_r == TIMEOUT_MAX) begin
            scan_lost <= 1'b1;
        end else begin
            to_cnt_r <= to_cnt_r + TW'(1);
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
module tb_seg_scan_decoder;

    logic       clk_100MHz = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] anodes = 8'hFF;
    logic [7:0] cathodes = 8'hFF;
    logic [3:0] digit_h, digit_t, digit_u;
    logic       blank_h, blank_t;
    logic [7:0] alarm_seg;
    logic       frame_valid, decode_error, seq_error, scan_lost;

    int checks = 0;
    int failures = 0;
    int fv_cnt = 0;
    int se_cnt = 0;

    seg_scan_decoder #(.STABLE_CYCLES(4), .FRAME_TIMEOUT(300)) dut (
        .clk_100MHz(clk_100MHz), .reset(reset), .anodes(anodes), .cathodes(cathodes),
        .digit_h(digit_h), .digit_t(digit_t), .digit_u(digit_u),
        .blank_h(blank_h), .blank_t(blank_t), .alarm_seg(alarm_seg),
        .frame_valid(frame_valid), .decode_error(decode_error),
        .seq_error(seq_error), .scan_lost(scan_lost)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    // Count high cycles of the pulse outputs, sampled on the falling edge.
    always @(negedge clk_100MHz) begin
        if (frame_valid === 1'b1) fv_cnt++;
        if (seq_error === 1'b1) se_cnt++;
    end

    // Present one pattern and hold it for n cycles; exits at posedge+1.
    task automatic drive(input logic [7:0] an, input logic [7:0] ca, input int n);
        anodes = an;
        cathodes = ca;
        repeat (n) @(posedge clk_100MHz);
        #1;
    endtask

    task automatic scan(input logic [7:0] c0, input logic [7:0] c1,
                        input logic [7:0] c2, input logic [7:0] c3);
        drive(8'h7F, c0, 100);
        drive(8'hBF, c1, 100);
        drive(8'hDF, c2, 100);
        drive(8'hEF, c3, 100);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(posedge clk_100MHz);
        #1;
        checks++;
        if ({digit_h, digit_t, digit_u} !== 12'h000) begin
            failures++; $display("FAIL reset_digits: got %h expected 000", {digit_h, digit_t, digit_u});
        end
        checks++;
        if (alarm_seg !== 8'hFF) begin
            failures++; $display("FAIL reset_alarm: got %h expected ff", alarm_seg);
        end
        checks++;
        if ({blank_h, blank_t, frame_valid, decode_error, seq_error, scan_lost} !== 6'b0) begin
            failures++; $display("FAIL reset_flags: got %b expected 000000",
                                 {blank_h, blank_t, frame_valid, decode_error, seq_error, scan_lost});
        end
        reset = 1'b1;
        drive(8'hFF, 8'hFF, 5);
    endtask

    task automatic test_basic_frame;
        int fv0 = fv_cnt;
        int lat = 0;
        drive(8'h7F, 8'h9F, 100);
        drive(8'hBF, 8'h25, 100);
        drive(8'hDF, 8'h0D, 100);
        anodes = 8'hEF;
        cathodes = 8'h00;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk_100MHz);
            #1;
            if (frame_valid === 1'b1 && lat == 0) lat = k;
        end
        drive(8'hEF, 8'h00, 80);
        checks++;
        if (lat != 7) begin
            failures++; $display("FAIL basic_latency: got %0d expected 7", lat);
        end
        checks++;
        if ({digit_h, digit_t, digit_u} !== 12'h123) begin
            failures++; $display("FAIL basic_digits: got %h expected 123", {digit_h, digit_t, digit_u});
        end
        checks++;
        if ({blank_h, blank_t, decode_error} !== 3'b000 || alarm_seg !== 8'h00) begin
            failures++; $display("FAIL basic_flags: got %b/%h expected 000/00",
                                 {blank_h, blank_t, decode_error}, alarm_seg);
        end
        scan(8'h9F, 8'h25, 8'h0D, 8'h00);
        checks++;
        if (fv_cnt - fv0 != 2) begin
            failures++; $display("FAIL basic_fv_count: got %0d expected 2", fv_cnt - fv0);
        end
    endtask

    task automatic test_blank;
        scan(8'hFF, 8'hFF, 8'h1F, 8'hA5);
        checks++;
        if ({digit_h, digit_t, digit_u} !== 12'hFF7) begin
            failures++; $display("FAIL blank_digits: got %h expected ff7", {digit_h, digit_t, digit_u});
        end
        checks++;
        if ({blank_h, blank_t, decode_error} !== 3'b110 || alarm_seg !== 8'hA5) begin
            failures++; $display("FAIL blank_flags: got %b/%h expected 110/a5",
                                 {blank_h, blank_t, decode_error}, alarm_seg);
        end
    endtask

    task automatic test_glitch;
        int fv0 = fv_cnt;
        int se0 = se_cnt;
        drive(8'h7F, 8'h03, 100);
        drive(8'hDF, 8'h01, 2);
        drive(8'hBF, 8'h99, 100);
        drive(8'hDF, 8'h49, 100);
        drive(8'hEF, 8'h41, 100);
        checks++;
        if (fv_cnt - fv0 != 1 || se_cnt != se0) begin
            failures++; $display("FAIL glitch_pulses: got fv=%0d se=%0d expected fv=1 se=0",
                                 fv_cnt - fv0, se_cnt - se0);
        end
        checks++;
        if ({digit_h, digit_t, digit_u} !== 12'h045 || blank_h !== 1'b0) begin
            failures++; $display("FAIL glitch_digits: got %h expected 045", {digit_h, digit_t, digit_u});
        end
    endtask

    task automatic test_seq_error;
        int fv0 = fv_cnt;
        int se0 = se_cnt;
        drive(8'h7F, 8'h01, 100);
        drive(8'hDF, 8'h09, 100);
        drive(8'hEF, 8'h41, 100);
        checks++;
        if (se_cnt - se0 != 1 || fv_cnt != fv0) begin
            failures++; $display("FAIL seq_skip: got se=%0d fv=%0d expected se=1 fv=0",
                                 se_cnt - se0, fv_cnt - fv0);
        end
        scan(8'h01, 8'h09, 8'h41, 8'hFF);
        checks++;
        if ({digit_h, digit_t, digit_u} !== 12'h896 || fv_cnt - fv0 != 1) begin
            failures++; $display("FAIL seq_recover: got %h fv=%0d expected 896 fv=1",
                                 {digit_h, digit_t, digit_u}, fv_cnt - fv0);
        end
        // Repeated slot 0 restarts the frame with the newer hundreds digit.
        drive(8'h7F, 8'h9F, 100);
        drive(8'h7F, 8'h25, 100);
        drive(8'hBF, 8'h0D, 100);
        drive(8'hDF, 8'h99, 100);
        drive(8'hEF, 8'h00, 100);
        checks++;
        if ({digit_h, digit_t, digit_u} !== 12'h234 || se_cnt - se0 != 2) begin
            failures++; $display("FAIL seq_restart: got %h se=%0d expected 234 se=2",
                                 {digit_h, digit_t, digit_u}, se_cnt - se0);
        end
    endtask

    task automatic test_decode_error;
        int fv0 = fv_cnt;
        scan(8'h02, 8'h55, 8'h49, 8'h00);
        checks++;
        if ({digit_h, digit_t, digit_u} !== 12'h0E5 || decode_error !== 1'b1 || fv_cnt - fv0 != 1) begin
            failures++; $display("FAIL decerr_set: got %h de=%b expected 0e5 de=1",
                                 {digit_h, digit_t, digit_u}, decode_error);
        end
        scan(8'h41, 8'h1F, 8'h01, 8'h00);
        checks++;
        if ({digit_h, digit_t, digit_u} !== 12'h678 || decode_error !== 1'b0) begin
            failures++; $display("FAIL decerr_clear: got %h de=%b expected 678 de=0",
                                 {digit_h, digit_t, digit_u}, decode_error);
        end
    endtask

    task automatic test_timeout;
        logic sl_at_fv = 1'bx;
        logic seen = 1'b0;
        drive(8'hFF, 8'hFF, 50);
        checks++;
        if (scan_lost !== 1'b0) begin
            failures++; $display("FAIL timeout_early: got %b expected 0", scan_lost);
        end
        drive(8'hFF, 8'hFF, 300);
        checks++;
        if (scan_lost !== 1'b1) begin
            failures++; $display("FAIL timeout_set: got %b expected 1", scan_lost);
        end
        drive(8'h7F, 8'h9F, 100);
        drive(8'hBF, 8'h9F, 100);
        drive(8'hDF, 8'h9F, 100);
        checks++;
        if (scan_lost !== 1'b1) begin
            failures++; $display("FAIL timeout_sticky: got %b expected 1", scan_lost);
        end
        anodes = 8'hEF;
        cathodes = 8'h00;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk_100MHz);
            #1;
            if (frame_valid === 1'b1 && !seen) begin
                seen = 1'b1;
                sl_at_fv = scan_lost;
            end
        end
        checks++;
        if (!seen || sl_at_fv !== 1'b0) begin
            failures++; $display("FAIL timeout_clear: got fv_seen=%b scan_lost=%b expected 1/0",
                                 seen, sl_at_fv);
        end
        drive(8'hEF, 8'h00, 80);
    endtask

    task automatic test_reset_mid_frame;
        int fv0;
        scan(8'h9F, 8'h25, 8'h0D, 8'h00);
        drive(8'h7F, 8'h01, 100);
        drive(8'hBF, 8'h01, 100);
        reset = 1'b0;
        @(posedge clk_100MHz);
        #1;
        checks++;
        if ({digit_h, digit_t, digit_u} !== 12'h000 || alarm_seg !== 8'hFF
            || {blank_h, blank_t, frame_valid, decode_error, seq_error, scan_lost} !== 6'b0) begin
            failures++; $display("FAIL midreset_outputs: got %h/%h expected 000/ff",
                                 {digit_h, digit_t, digit_u}, alarm_seg);
        end
        reset = 1'b1;
        fv0 = fv_cnt;
        drive(8'hBF, 8'h01, 20);
        drive(8'hDF, 8'h03, 100);
        drive(8'hEF, 8'h00, 100);
        checks++;
        if (fv_cnt != fv0 || {digit_h, digit_t, digit_u} !== 12'h000) begin
            failures++; $display("FAIL midreset_discard: got fv=%0d digits=%h expected fv=0 digits=000",
                                 fv_cnt - fv0, {digit_h, digit_t, digit_u});
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_blank();
        test_glitch();
        test_seq_error();
        test_decode_error();
        test_timeout();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
